// File: rtl/cla_pkg.sv
// Shared definitions for the carry-lookahead add/subtract unit: opcodes,
// the default leaf size and the generate/propagate group combine.
package cla_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ADC = 2'b10;
  localparam logic [1:0] OP_SBB = 2'b11;

  localparam int DEFAULT_BLOCK = 8;

  // Merge a high group (g_h,p_h) with the adjacent low group (g_l,p_l); returns {G,P}
  function automatic logic [1:0] gp_combine(input logic g_h, input logic p_h,
                                            input logic g_l, input logic p_l);
    return {g_h | (p_h & g_l), p_h & p_l};
  endfunction

endpackage

// File: rtl/cla_addsub_pipe_if.sv
// Operand/result bus of the pipelined add/subtract unit.
interface cla_addsub_pipe_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [1:0]       OP;
  logic             CI;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] S;
  logic             CO;
  logic             OV;
  logic             Z;
  logic             N;

  modport master (output in_valid, A, B, OP, CI, out_ready,
                  input  in_ready, out_valid, S, CO, OV, Z, N);
  modport slave  (input  in_valid, A, B, OP, CI, out_ready,
                  output in_ready, out_valid, S, CO, OV, Z, N);
endinterface

// File: rtl/cla_block_gp.sv
// BLOCK-bit leaf carry-lookahead adder for a fixed carry-in. Produces the
// local sum, block generate/propagate and the carry into the block MSB.
module cla_block_gp import cla_pkg::*; #(
  parameter int BLOCK = DEFAULT_BLOCK
) (
  input  logic [BLOCK-1:0] a_i,
  input  logic [BLOCK-1:0] b_i,
  input  logic             ci_i,
  output logic [BLOCK-1:0] s_o,
  output logic             g_o,
  output logic             p_o,
  output logic             cmsb_o
);
  localparam int LVL = $clog2(BLOCK);

  logic [LVL:0][BLOCK-1:0] g_t;
  logic [LVL:0][BLOCK-1:0] p_t;
  logic [BLOCK-1:0]        c;

  // Prefix tree: after level l every bit i holds the group (i .. i-2^(l+1)+1)
  always_comb begin
    g_t    = '0;
    p_t    = '0;
    g_t[0] = a_i & b_i;
    p_t[0] = a_i ^ b_i;
    for (int l = 0; l < LVL; l++) begin
      for (int i = 0; i < BLOCK; i++) begin
        if (i >= (1 << l)) begin
          {g_t[l+1][i], p_t[l+1][i]} = gp_combine(g_t[l][i], p_t[l][i],
                                                  g_t[l][i-(1<<l)], p_t[l][i-(1<<l)]);
        end else begin
          g_t[l+1][i] = g_t[l][i];
          p_t[l+1][i] = p_t[l][i];
        end
      end
    end
  end

  // Carry into each bit from the prefix groups below it, then the sum
  always_comb begin
    c    = '0;
    c[0] = ci_i;
    for (int i = 1; i < BLOCK; i++) begin
      c[i] = g_t[LVL][i-1] | (p_t[LVL][i-1] & ci_i);
    end
  end

  assign s_o    = p_t[0] ^ c;
  assign g_o    = g_t[LVL][BLOCK-1];
  assign p_o    = p_t[LVL][BLOCK-1];
  assign cmsb_o = c[BLOCK-1];

endmodule

// File: rtl/cla_addsub_pipe.sv
// Three-stage pipelined WIDTH-bit add/subtract with carry-select leaf blocks
// and a block-level lookahead tree. Whole pipe advances or holds together.
module cla_addsub_pipe import cla_pkg::*; #(
  parameter  int WIDTH = 32,
  parameter  int BLOCK = DEFAULT_BLOCK,
  localparam int NB    = WIDTH / BLOCK
) (
  input logic              clk,
  input logic              rst_n,
  cla_addsub_pipe_if.slave bus
);
  localparam int LVL = $clog2(NB);

  if ((WIDTH % BLOCK) != 0 || NB < 2) begin : g_bad_params
    $error("cla_addsub_pipe: WIDTH must be a multiple of BLOCK with at least two blocks");
  end

  logic adv;
  logic vld_p1_q, vld_p2_q, vld_p3_q;

  logic [WIDTH-1:0] beff_p1_d, a_p1_q, beff_p1_q;
  logic             c0_p1_d, c0_p1_q;

  logic [NB-1:0][BLOCK-1:0] s0_p2_d, s1_p2_d, s0_p2_q, s1_p2_q;
  logic [NB-1:0]            g_p2_d, p_p2_d, g_p2_q, p_p2_q;
  logic                     cm0_top, cm1_top, cm0_p2_q, cm1_p2_q, c0_p2_q;

  logic [LVL:0][NB-1:0]     gb_t, pb_t;
  logic [NB-1:0]            c_blk;
  logic [NB-1:0][BLOCK-1:0] s_sel;
  logic [WIDTH-1:0]         s_p3_d, s_p3_q;
  logic                     co_p3_d, ov_p3_d, co_p3_q, ov_p3_q, z_p3_q, n_p3_q;

  assign adv          = ~vld_p3_q | bus.out_ready;
  assign bus.in_ready = adv;

  // ---- stage 1: operand preparation (B inverted for subtract, carry-in chosen)
  // Map opcode onto effective B and initial carry
  always_comb begin
    beff_p1_d = bus.B;
    c0_p1_d   = 1'b0;
    case (bus.OP)
      OP_ADD:  c0_p1_d = 1'b0;
      OP_SUB:  begin beff_p1_d = ~bus.B; c0_p1_d = 1'b1;   end
      OP_ADC:  c0_p1_d = bus.CI;
      default: begin beff_p1_d = ~bus.B; c0_p1_d = bus.CI; end
    endcase
  end

  // Capture an accepted beat
  always_ff @(posedge clk) begin
    if (adv && bus.in_valid) begin
      a_p1_q    <= bus.A;
      beff_p1_q <= beff_p1_d;
      c0_p1_q   <= c0_p1_d;
    end
  end

  // ---- stage 2: leaf blocks evaluated for both possible carry-ins
  for (genvar k = 0; k < NB; k++) begin : g_blk
    logic g1_k, p1_k, cm0_k, cm1_k;

    cla_block_gp #(.BLOCK(BLOCK)) u_ci0 (
      .a_i(a_p1_q[k*BLOCK +: BLOCK]), .b_i(beff_p1_q[k*BLOCK +: BLOCK]), .ci_i(1'b0),
      .s_o(s0_p2_d[k]), .g_o(g_p2_d[k]), .p_o(p_p2_d[k]), .cmsb_o(cm0_k)
    );
    cla_block_gp #(.BLOCK(BLOCK)) u_ci1 (
      .a_i(a_p1_q[k*BLOCK +: BLOCK]), .b_i(beff_p1_q[k*BLOCK +: BLOCK]), .ci_i(1'b1),
      .s_o(s1_p2_d[k]), .g_o(g1_k), .p_o(p1_k), .cmsb_o(cm1_k)
    );

    // G/P do not depend on carry-in, so the ci=1 copy's are redundant; only the
    // top block's MSB carries are needed (for signed overflow)
    if (k == NB-1) begin : g_top
      logic unused_gp;
      assign cm0_top   = cm0_k;
      assign cm1_top   = cm1_k;
      assign unused_gp = g1_k ^ p1_k;
    end else begin : g_low
      logic unused_gp;
      assign unused_gp = g1_k ^ p1_k ^ cm0_k ^ cm1_k;
    end
  end

  // Register both candidate sums and the block generate/propagate
  always_ff @(posedge clk) begin
    if (adv && vld_p1_q) begin
      s0_p2_q  <= s0_p2_d;
      s1_p2_q  <= s1_p2_d;
      g_p2_q   <= g_p2_d;
      p_p2_q   <= p_p2_d;
      cm0_p2_q <= cm0_top;
      cm1_p2_q <= cm1_top;
      c0_p2_q  <= c0_p1_q;
    end
  end

  // ---- stage 3: block lookahead, sum select, flags
  // Block-level prefix tree: level l merges spans of 2^l blocks
  always_comb begin
    gb_t    = '0;
    pb_t    = '0;
    gb_t[0] = g_p2_q;
    pb_t[0] = p_p2_q;
    for (int l = 0; l < LVL; l++) begin
      for (int i = 0; i < NB; i++) begin
        if (i >= (1 << l)) begin
          {gb_t[l+1][i], pb_t[l+1][i]} = gp_combine(gb_t[l][i], pb_t[l][i],
                                                    gb_t[l][i-(1<<l)], pb_t[l][i-(1<<l)]);
        end else begin
          gb_t[l+1][i] = gb_t[l][i];
          pb_t[l+1][i] = pb_t[l][i];
        end
      end
    end
  end

  // Per-block carry-in selects the precomputed sum; carry/overflow from the tree
  always_comb begin
    c_blk    = '0;
    c_blk[0] = c0_p2_q;
    for (int k = 1; k < NB; k++) begin
      c_blk[k] = gb_t[LVL][k-1] | (pb_t[LVL][k-1] & c0_p2_q);
    end
    s_sel = '0;
    for (int k = 0; k < NB; k++) begin
      s_sel[k] = c_blk[k] ? s1_p2_q[k] : s0_p2_q[k];
    end
    s_p3_d  = s_sel;
    co_p3_d = gb_t[LVL][NB-1] | (pb_t[LVL][NB-1] & c0_p2_q);
    ov_p3_d = co_p3_d ^ (c_blk[NB-1] ? cm1_p2_q : cm0_p2_q);
  end

  // Valid bits march with their data; outputs clear on reset and hold on stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      vld_p3_q <= 1'b0;
      s_p3_q   <= '0;
      co_p3_q  <= 1'b0;
      ov_p3_q  <= 1'b0;
      z_p3_q   <= 1'b0;
      n_p3_q   <= 1'b0;
    end else if (adv) begin
      vld_p1_q <= bus.in_valid;
      vld_p2_q <= vld_p1_q;
      vld_p3_q <= vld_p2_q;
      if (vld_p2_q) begin
        s_p3_q  <= s_p3_d;
        co_p3_q <= co_p3_d;
        ov_p3_q <= ov_p3_d;
        z_p3_q  <= ~|s_p3_d;
        n_p3_q  <= s_p3_d[WIDTH-1];
      end
    end
  end

  assign bus.out_valid = vld_p3_q;
  assign bus.S         = s_p3_q;
  assign bus.CO        = co_p3_q;
  assign bus.OV        = ov_p3_q;
  assign bus.Z         = z_p3_q;
  assign bus.N         = n_p3_q;

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Bench for cla_addsub_pipe: directed cases on a 32-bit unit plus random
// sweeps of 16/4 and 64/8 configurations against an arithmetic model.
module tb_cla_addsub_pipe;
  import cla_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic rst_sw_n;
  int   n_chk = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Integer reference: returns {S[63:0], CO, OV, Z, N} for width w
  function automatic logic [67:0] ref_op(input int w, input logic [63:0] a, input logic [63:0] b,
                                         input logic [1:0] op, input logic ci);
    logic signed [67:0] ua, ub, sa, sb, ur, sr, k, lim;
    logic [63:0] s;
    logic co, ov;
    ua = $signed({4'b0, a});
    ub = $signed({4'b0, b});
    sa = ua;
    sb = ub;
    if (a[w-1]) sa = ua - (68'sd1 <<< w);
    if (b[w-1]) sb = ub - (68'sd1 <<< w);
    k = 68'sd0;
    if (op == OP_ADC && ci)  k = 68'sd1;
    if (op == OP_SBB && !ci) k = 68'sd1;
    if (op == OP_ADD || op == OP_ADC) begin
      ur = ua + ub + k;
      sr = sa + sb + k;
      co = (ur >= (68'sd1 <<< w));
    end else begin
      ur = ua - ub - k;
      sr = sa - sb - k;
      co = (ur >= 68'sd0);
    end
    lim = 68'sd1 <<< (w - 1);
    ov  = (sr >= lim) || (sr < -lim);
    s   = ur[63:0];
    if (w < 64) s = s & ((64'd1 << w) - 64'd1);
    return {s, co, ov, (s == 64'd0), s[w-1]};
  endfunction

  cla_addsub_pipe_if #(.WIDTH(32)) bus ();
  cla_addsub_pipe #(.WIDTH(32), .BLOCK(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // One isolated beat: accepted at edge t, result must be offered for edge t+3
  task automatic run1(input string tag, input logic [1:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic ci,
                      input logic [31:0] es, input logic [3:0] ef);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.A = a; bus.B = b; bus.OP = op; bus.CI = ci; bus.out_ready = 1'b1;
    #1 check({tag, "/in_ready"}, 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    bus.in_valid = 1'b0; bus.A = $urandom; bus.B = $urandom;
    #1 check({tag, "/early1"}, 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    #1 check({tag, "/early2"}, 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    #1 check({tag, "/valid"}, 64'(bus.out_valid), 64'd1);
    check({tag, "/S"}, 64'(bus.S), 64'(es));
    check({tag, "/CO_OV_Z_N"}, 64'({bus.CO, bus.OV, bus.Z, bus.N}), 64'(ef));
  endtask

  // Eight back-to-back ADDs with downstream stalled in cycles 4..6
  task automatic stall_test();
    logic [31:0] expq[$];
    logic [31:0] held;
    int sent, got, cyc;
    sent = 0; got = 0; cyc = 0; held = '0;
    while (got < 8 && cyc < 40) begin
      @(negedge clk);
      bus.in_valid  = (sent < 8);
      bus.A         = 32'(sent);
      bus.B         = 32'(sent) * 32'h01010101;
      bus.OP        = OP_ADD;
      bus.CI        = 1'($urandom);
      bus.out_ready = !(cyc >= 4 && cyc <= 6);
      #1;
      if (cyc >= 4 && cyc <= 6) begin
        check("stall/in_ready", 64'(bus.in_ready), 64'd0);
        if (cyc == 4) held = bus.S;
        else check("stall/S_held", 64'(bus.S), 64'(held));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (expq.size() == 0) check("stall/spurious", 64'(bus.out_valid), 64'd0);
        else check("stall/S", 64'(bus.S), 64'(expq.pop_front()));
        got++;
      end
      if (bus.in_valid && bus.in_ready) begin
        expq.push_back(32'(sent) + 32'(sent) * 32'h01010101);
        sent++;
      end
      cyc++;
    end
    check("stall/retired", 64'(got), 64'd8);
    check("stall/accepted", 64'(sent), 64'd8);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1 check("stall/no_dup", 64'(bus.out_valid), 64'd0);
  endtask

  // Random sweeps on other geometries, each with its own scoreboard
  for (genvar g = 0; g < 2; g++) begin : g_sweep
    localparam int W  = (g == 0) ? 16 : 64;
    localparam int BK = (g == 0) ? 4 : 8;
    cla_addsub_pipe_if #(.WIDTH(W)) sb ();
    cla_addsub_pipe #(.WIDTH(W), .BLOCK(BK)) dut (.clk(clk), .rst_n(rst_sw_n), .bus(sb));
    bit done = 1'b0;

    initial begin
      logic [67:0] q[$];
      logic [67:0] e;
      logic [63:0] a, b, msk;
      int acc, cyc;
      acc = 0; cyc = 0;
      msk = '1;
      msk = msk >> (64 - W);
      sb.in_valid = 1'b0; sb.A = '0; sb.B = '0; sb.OP = OP_ADD; sb.CI = 1'b0; sb.out_ready = 1'b1;
      wait (rst_sw_n === 1'b1);
      while ((acc < 10000 || q.size() > 0) && cyc < 40000) begin
        @(negedge clk);
        a = {$urandom, $urandom} & msk;
        b = {$urandom, $urandom} & msk;
        sb.in_valid  = (acc < 10000) && ($urandom_range(0, 9) < 8);
        sb.A         = a[W-1:0];
        sb.B         = b[W-1:0];
        sb.OP        = 2'($urandom);
        sb.CI        = 1'($urandom);
        sb.out_ready = ($urandom_range(0, 9) < 8) || (acc >= 10000);
        #1;
        if (sb.out_valid && sb.out_ready) begin
          if (q.size() == 0) begin
            check($sformatf("w%0d/spurious", W), 64'(sb.out_valid), 64'd0);
          end else begin
            e = q.pop_front();
            check($sformatf("w%0d/S", W), 64'(sb.S), e[67:4]);
            check($sformatf("w%0d/CO_OV_Z_N", W), 64'({sb.CO, sb.OV, sb.Z, sb.N}), 64'(e[3:0]));
          end
        end
        if (sb.in_valid && sb.in_ready) begin
          q.push_back(ref_op(W, a, b, sb.OP, sb.CI));
          acc++;
        end
        cyc++;
      end
      check($sformatf("w%0d/accepted", W), 64'(acc), 64'd10000);
      check($sformatf("w%0d/drained", W), 64'(q.size()), 64'd0);
      sb.in_valid = 1'b0;
      done = 1'b1;
    end
  end

  initial begin
    rst_n = 1'b0; rst_sw_n = 1'b0;
    bus.in_valid = 1'b0; bus.A = '0; bus.B = '0; bus.OP = OP_ADD; bus.CI = 1'b0; bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("reset/out_valid", 64'(bus.out_valid), 64'd0);
    check("reset/S", 64'(bus.S), 64'd0);
    check("reset/flags", 64'({bus.CO, bus.OV, bus.Z, bus.N}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1; rst_sw_n = 1'b1;
    #1 check("reset/in_ready", 64'(bus.in_ready), 64'd1);

    run1("add_wrap", OP_ADD, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 4'b1010);
    run1("sub_ovf",  OP_SUB, 32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 4'b1100);
    run1("adc_ci1",  OP_ADC, 32'h0000FFFF, 32'h00000000, 1'b1, 32'h00010000, 4'b0000);
    run1("sbb_ci0",  OP_SBB, 32'h00000005, 32'h00000005, 1'b0, 32'hFFFFFFFF, 4'b0001);
    run1("sub_eq",   OP_SUB, 32'h12345678, 32'h12345678, 1'b0, 32'h00000000, 4'b1010);
    run1("add_ci_ignored", OP_ADD, 32'h7FFFFFFF, 32'h00000001, 1'b1, 32'h80000000, 4'b0101);

    stall_test();

    // Two beats in flight when reset hits; neither may ever emerge
    @(negedge clk);
    bus.in_valid = 1'b1; bus.A = 32'd1; bus.B = 32'd1; bus.OP = OP_ADD; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.A = 32'd2; bus.B = 32'd2;
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check("rst_mid/out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_mid/S", 64'(bus.S), 64'd0);
    @(negedge clk);
    check("rst_mid/during", 64'(bus.out_valid), 64'd0);
    rst_n = 1'b1;
    #1 check("rst_mid/after", 64'(bus.out_valid), 64'd0);
    run1("rst_add", OP_ADD, 32'd3, 32'd4, 1'b0, 32'h00000007, 4'b0000);
    repeat (2) begin
      @(negedge clk);
      #1 check("rst_mid/no_stale", 64'(bus.out_valid), 64'd0);
    end

    for (int i = 0; i < 50000 && !(g_sweep[0].done && g_sweep[1].done); i++) @(negedge clk);
    check("sweep16/finished", 64'(g_sweep[0].done), 64'd1);
    check("sweep64/finished", 64'(g_sweep[1].done), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
